// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Summary  : LEGv8 instruction fetch with one outstanding imem request, an
//            IF/ID register with a one-entry hold buffer, and branch redirect.
//            Optional perf counters are enabled by FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int unsigned  N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         stall_d,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [N-1:0] if_pc,
  output logic [10:0]  if_op
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);

  localparam logic [N-1:0] c_pc_step  = N'(4);
  localparam logic [N-1:0] c_low_mask = N'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t         r_state;
  logic           r_drop;
  logic           r_imem_req;
  logic [N-1:0]   r_pc;
  logic           r_if_valid;
  logic [31:0]    r_if_instr;
  logic [N-1:0]   r_if_pc;
  logic [31:0]    r_hold_instr;
  logic [N-1:0]   r_hold_pc;

  logic           w_consume;
  logic           w_free;
  logic           w_br;
  logic           w_load_wait;
  logic           w_load_hold;
  logic           w_load;
  logic [N-1:0]   w_br_pc;

  assign w_consume   = r_if_valid && !stall_d;
  assign w_free      = !r_if_valid || w_consume;
  assign w_br        = br_taken && (r_state != S_IDLE);
  assign w_br_pc     = br_target & ~c_low_mask;
  assign w_load_wait = !w_br && (r_state == S_WAIT) && imem_rvalid && !r_drop && w_free;
  assign w_load_hold = !w_br && (r_state == S_HOLD) && w_consume;
  assign w_load      = w_load_wait || w_load_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_drop       <= 1'b0;
      r_imem_req   <= 1'b0;
      r_pc         <= RESET_PC;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else begin
      r_imem_req <= 1'b0;
      if (w_br) begin
        // Redirect wins over everything; a response still owed must be dropped
        r_pc       <= w_br_pc;
        r_if_valid <= 1'b0;
        r_state    <= S_ISSUE;
        r_imem_req <= 1'b1;
        if ((r_state == S_ISSUE) || ((r_state == S_WAIT) && !imem_rvalid)) begin
          r_drop <= 1'b1;
        end else if (r_state == S_WAIT) begin
          r_drop <= 1'b0;
        end
      end else begin
        if (w_load_wait) begin
          r_if_instr <= imem_rdata;
          r_if_pc    <= r_pc;
        end else if (w_load_hold) begin
          r_if_instr <= r_hold_instr;
          r_if_pc    <= r_hold_pc;
        end

        if (w_load) begin
          r_if_valid <= 1'b1;
          r_pc       <= r_pc + c_pc_step;
        end else if (w_consume) begin
          r_if_valid <= 1'b0;
        end

        case (r_state)
          S_IDLE: begin
            r_state    <= S_ISSUE;
            r_imem_req <= 1'b1;
          end
          S_ISSUE: begin
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              if (r_drop) begin
                r_drop     <= 1'b0;
                r_state    <= S_ISSUE;
                r_imem_req <= 1'b1;
              end else if (w_free) begin
                r_state    <= S_ISSUE;
                r_imem_req <= 1'b1;
              end else begin
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= r_pc;
                r_state      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (w_consume) begin
              r_state    <= S_ISSUE;
              r_imem_req <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign if_op     = r_if_instr[31:21];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Both counters saturate rather than wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_load && (r_perf_fetched != 32'hFFFF_FFFF)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (r_if_valid && stall_d && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire
